// File: rtl/cv32e40p_ft_error_monitor.sv
// Error monitor behind the voter bank: saturating event counters, windowed corrected-error
// density, recovery req/ack and a sticky fatal alarm. CV32E40P_FT_ERR_LOG_EN adds a first-error log.
module cv32e40p_ft_error_monitor #(
   parameter int unsigned N_VOTERS = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WINDOW   = 1024,
   parameter int unsigned THRESH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [N_VOTERS-1:0] err_correct_i,
   input  logic [N_VOTERS-1:0] err_detected_i,
   input  logic                clear_i,
   input  logic                recover_ack_i,
`ifdef CV32E40P_FT_ERR_LOG_EN
   output logic                err_log_valid_o,
   output logic [((N_VOTERS > 1) ? $clog2(N_VOTERS) : 1)-1:0] err_log_idx_o,
`endif
   output logic                recover_req_o,
   output logic                fatal_o,
   output logic [1:0]          state_o,
   output logic [CNT_W-1:0]    corr_cnt_o,
   output logic [CNT_W-1:0]    uncorr_cnt_o
);

   localparam int unsigned TMR_W = $clog2(WINDOW);
   localparam int unsigned WC_W  = $clog2(THRESH + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
   localparam logic [WC_W:0]    THRESH_V = (WC_W + 1)'(THRESH);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_RECOVER = 2'd1,
      ST_FATAL   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             corr_evt, uncorr_evt;
   logic [TMR_W-1:0] timer_q;
   logic [WC_W-1:0]  win_cnt_q, win_next;
   logic [WC_W:0]    win_sum;
   logic             thr_hit;
   logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

   assign corr_evt   = valid_i & (|(err_detected_i & err_correct_i));
   assign uncorr_evt = valid_i & (|(err_detected_i & ~err_correct_i));

   // The current cycle's event counts toward the threshold before the window rolls over.
   assign win_sum  = {1'b0, win_cnt_q} + {{WC_W{1'b0}}, corr_evt};
   assign thr_hit  = (win_sum >= THRESH_V);
   assign win_next = thr_hit ? WC_W'(THRESH) : win_sum[WC_W-1:0];

   // Recovery handshake: recover_req_o rises when RECOVER is entered and stays high and
   // unchanged until recover_ack_i is sampled high at a clock edge while in RECOVER; it
   // drops the following cycle. An ack outside RECOVER has no effect.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_OK;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OK: begin
            if (uncorr_evt)   state_d = ST_FATAL;
            else if (thr_hit) state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (uncorr_evt)         state_d = ST_FATAL;
            else if (recover_ack_i) state_d = ST_OK;
         end
         ST_FATAL: state_d = ST_FATAL;
         default:  state_d = ST_OK;
      endcase
      if (clear_i) state_d = ST_OK;
   end

   // Window timer and density count advance only in OK; they restart on every return to OK.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         timer_q   <= '0;
         win_cnt_q <= '0;
      end else if (state_q == ST_OK) begin
         if (timer_q == TMR_LAST) begin
            timer_q   <= '0;
            win_cnt_q <= '0;
         end else begin
            timer_q   <= timer_q + TMR_W'(1);
            win_cnt_q <= win_next;
         end
      end else if (state_d != state_q) begin
         timer_q   <= '0;
         win_cnt_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (state_q != ST_FATAL) begin
         if (corr_evt && !(&corr_cnt_q))     corr_cnt_q   <= corr_cnt_q + CNT_W'(1);
         if (uncorr_evt && !(&uncorr_cnt_q)) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
      end
   end

`ifdef CV32E40P_FT_ERR_LOG_EN
   localparam int unsigned IDX_W = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;

   logic [IDX_W-1:0] low_idx;
   logic             log_valid_q;
   logic [IDX_W-1:0] log_idx_q;

   always_comb begin
      low_idx = '0;
      for (int i = N_VOTERS - 1; i >= 0; i--) begin
         if (err_detected_i[i]) low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         log_valid_q <= 1'b0;
         log_idx_q   <= '0;
      end else if (!log_valid_q && (corr_evt || uncorr_evt)) begin
         log_valid_q <= 1'b1;
         log_idx_q   <= low_idx;
      end
   end

   assign err_log_valid_o = log_valid_q;
   assign err_log_idx_o   = log_idx_q;
`endif

   assign state_o       = state_q;
   assign recover_req_o = (state_q == ST_RECOVER);
   assign fatal_o       = (state_q == ST_FATAL);
   assign corr_cnt_o    = corr_cnt_q;
   assign uncorr_cnt_o  = uncorr_cnt_q;

endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Bench for cv32e40p_ft_error_monitor: directed scenarios with literal expectations, then
// randomized traffic against a cycle-indexed behavioural model through an expected queue.
module tb_cv32e40p_ft_error_monitor;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int WIN  = 16;
   localparam int TH   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int EW   = 4 + 2 * CW;

   logic          clk = 1'b0;
   logic          rst, valid_i, clear_i, recover_ack_i;
   logic [N-1:0]  err_correct_i, err_detected_i;
   logic          recover_req_o, fatal_o;
   logic [1:0]    state_o;
   logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;
`ifdef CV32E40P_FT_ERR_LOG_EN
   logic          err_log_valid_o;
   logic [1:0]    err_log_idx_o;
   logic [2:0]    log_q[$];
`endif

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   cv32e40p_ft_error_monitor #(
      .N_VOTERS(N), .CNT_W(CW), .WINDOW(WIN), .THRESH(TH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .err_correct_i  (err_correct_i),
      .err_detected_i (err_detected_i),
      .clear_i        (clear_i),
      .recover_ack_i  (recover_ack_i),
`ifdef CV32E40P_FT_ERR_LOG_EN
      .err_log_valid_o(err_log_valid_o),
      .err_log_idx_o  (err_log_idx_o),
`endif
      .recover_req_o  (recover_req_o),
      .fatal_o        (fatal_o),
      .state_o        (state_o),
      .corr_cnt_o     (corr_cnt_o),
      .uncorr_cnt_o   (uncorr_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode 0 OK, 1 RECOVER, 2 FATAL. The window is tracked as the cycle it opened and the
   // corrected events seen since; it reopens whenever the model returns to OK.
   int cyc = 0;
   int m_mode = 0, m_corr = 0, m_unc = 0, m_win_start = 0, m_win_evts = 0;
   bit m_lv = 0;
   int m_li = 0;

   function automatic int lowest(input logic [N-1:0] d);
      for (int i = 0; i < N; i++) if (d[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      bit ce, ue;
      int tot;
      ce = valid_i && ((err_detected_i & err_correct_i) != 0);
      ue = valid_i && ((err_detected_i & ~err_correct_i) != 0);
      if (rst || clear_i) begin
         m_mode = 0; m_corr = 0; m_unc = 0; m_win_start = cyc + 1; m_win_evts = 0;
         m_lv = 0; m_li = 0;
      end else begin
         if (m_mode != 2) begin
            if (ce) m_corr = (m_corr < CMAX) ? m_corr + 1 : CMAX;
            if (ue) m_unc  = (m_unc  < CMAX) ? m_unc  + 1 : CMAX;
         end
         if (!m_lv && (ce || ue)) begin
            m_lv = 1;
            m_li = lowest(err_detected_i);
         end
         if (m_mode == 0) begin
            tot = m_win_evts + int'(ce);
            if (ue) m_mode = 2;
            else if (tot >= TH) m_mode = 1;
            if (cyc - m_win_start == WIN - 1) begin
               m_win_start = cyc + 1;
               m_win_evts  = 0;
            end else begin
               m_win_evts = tot;
            end
         end else if (m_mode == 1) begin
            if (ue) m_mode = 2;
            else if (recover_ack_i) begin
               m_mode = 0; m_win_start = cyc + 1; m_win_evts = 0;
            end
         end
      end
      exp_q.push_back({2'(m_mode), m_mode == 1, m_mode == 2, CW'(m_corr), CW'(m_unc)});
`ifdef CV32E40P_FT_ERR_LOG_EN
      log_q.push_back({m_lv, 2'(m_li)});
`endif
      cyc++;
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("state",  32'(state_o),       32'(e[2*CW+3:2*CW+2]));
         chk("req",    32'(recover_req_o), 32'(e[2*CW+1]));
         chk("fatal",  32'(fatal_o),       32'(e[2*CW]));
         chk("corr",   32'(corr_cnt_o),    32'(e[2*CW-1:CW]));
         chk("uncorr", 32'(uncorr_cnt_o),  32'(e[CW-1:0]));
      end
`ifdef CV32E40P_FT_ERR_LOG_EN
      if (log_q.size() > 0) begin
         logic [2:0] l;
         l = log_q.pop_front();
         chk("log_valid", 32'(err_log_valid_o), 32'(l[2]));
         chk("log_idx",   32'(err_log_idx_o),   32'(l[1:0]));
      end
`endif
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [N-1:0] d, input logic [N-1:0] c,
                        input logic clr, input logic ack);
      valid_i = v; err_detected_i = d; err_correct_i = c; clear_i = clr; recover_ack_i = ack;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic corr_ev(input logic [N-1:0] d);
      drive(1'b1, d, d, 1'b0, 1'b0);
   endtask

   task automatic pin(input string name, input logic [1:0] st, input int corr, input int unc);
      chk({name, "_state"},  32'(state_o),       32'(st));
      chk({name, "_req"},    32'(recover_req_o), 32'(st == 2'd1));
      chk({name, "_fatal"},  32'(fatal_o),       32'(st == 2'd2));
      chk({name, "_corr"},   32'(corr_cnt_o),    32'(corr));
      chk({name, "_uncorr"}, 32'(uncorr_cnt_o),  32'(unc));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; valid_i = 1'b0; clear_i = 1'b0; recover_ack_i = 1'b0;
      err_detected_i = '0; err_correct_i = '0;
      repeat (3) @(negedge clk);
      pin("reset", 2'd0, 0, 0);
      rst = 1'b0;

      // Threshold reached: four corrected events inside the first window.
      corr_ev(4'b1010); idle(1); corr_ev(4'b0010); idle(1); corr_ev(4'b0010);
      pin("below_thr", 2'd0, 3, 0);
      idle(1); corr_ev(4'b0010);
      pin("thr_hit", 2'd1, 4, 0);
`ifdef CV32E40P_FT_ERR_LOG_EN
      chk("log_first_valid", 32'(err_log_valid_o), 32'd1);
      chk("log_first_idx",   32'(err_log_idx_o),   32'd1);
`endif
      idle(5);
      pin("req_held", 2'd1, 4, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      pin("ack", 2'd0, 4, 0);

      // Three events, window expires, one more: no recovery.
      corr_ev(4'b0001); corr_ev(4'b0001); corr_ev(4'b0001);
      idle(20);
      corr_ev(4'b1000);
      pin("win_expire", 2'd0, 8, 0);
`ifdef CV32E40P_FT_ERR_LOG_EN
      chk("log_sticky_idx", 32'(err_log_idx_o), 32'd1);
`endif
      idle(8);
      corr_ev(4'b0100); corr_ev(4'b0100); corr_ev(4'b0100);
      pin("win2_three", 2'd0, 11, 0);
      corr_ev(4'b0100);
      pin("win2_thr", 2'd1, 12, 0);

      // Uncorrectable with a simultaneous ack wins: FATAL, req dropped.
      drive(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
      pin("fatal", 2'd2, 12, 1);
      drive(1'b1, 4'b0011, 4'b0001, 1'b0, 1'b1);
      corr_ev(4'b1111);
      pin("frozen", 2'd2, 12, 1);
      drive(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0);
      pin("clear", 2'd0, 0, 0);

      // Flags without valid are ignored.
      for (int i = 0; i < 5; i++) drive(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
      pin("no_valid", 2'd0, 0, 0);

      // Saturation: continuous events with ack always high.
      for (int i = 0; i < 20; i++) drive(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1);
      chk("sat_corr", 32'(corr_cnt_o), 32'(CMAX));
      drive(1'b0, '0, '0, 1'b1, 1'b0);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 4000; i++) begin
         logic [N-1:0] d, c;
         d = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 15)) : '0;
         c = N'($urandom);
         if ($urandom_range(0, 29) != 0) c = c | d;
         rst = ($urandom_range(0, 499) == 0);
         drive($urandom_range(0, 4) != 0, d, c, $urandom_range(0, 149) == 0,
               $urandom_range(0, 3) == 0);
      end
      rst = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
